// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor: BTB entry layout and
// the 2-bit PHT counter encoding.
package bp_pkg;

  // Tag is kept full-width; only the bits above the index are ever non-zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic        uncond;
  } btb_entry_t;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } pht_ctr_t;

  localparam pht_ctr_t PHT_RESET = WEAK_NT;

endpackage

// File: rtl/bp_sat_ctr2.sv
// Saturating 2-bit direction counter next-state function.
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  pht_ctr_t ctr,
  input  logic     taken,
  output pht_ctr_t ctr_next
);

  // Step toward the observed direction, holding at either end.
  always_comb begin
    ctr_next = ctr;
    unique case (ctr)
      STRONG_NT: ctr_next = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   ctr_next = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    ctr_next = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  ctr_next = taken ? STRONG_T : WEAK_T;
      default:   ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage next-PC predictor: direct-mapped BTB plus 2-bit PHT.
// Define BP_GSHARE_EN to XOR a global history register into the PHT index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_cond,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] predicted_pc,
  output logic        predict_taken,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int unsigned Entries = 1 << IDX_BITS;

  btb_entry_t btb_q [Entries];
  pht_ctr_t   pht_q [Entries];
  logic [31:0] branch_count_q, mispredict_count_q;

  logic [IDX_BITS-1:0] idx, pidx, upd_idx, upd_pidx;
  logic [31:0]         tag, upd_tag;
  btb_entry_t          lk_entry;
  pht_ctr_t            lk_ctr, ctr_next;
  logic                hit;

  assign idx     = fetch_pc[IDX_BITS+1:2];
  assign tag     = fetch_pc >> (IDX_BITS + 2);
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign upd_tag = upd_pc >> (IDX_BITS + 2);

`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q;

  assign pidx     = idx ^ ghr_q;
  assign upd_pidx = upd_idx ^ ghr_q;

  // Shift resolved conditional outcomes into history; the PHT write this
  // cycle still sees the pre-shift value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (upd_valid && upd_is_cond) begin
      ghr_q <= {ghr_q[IDX_BITS-2:0], upd_taken};
    end
  end
`else
  assign pidx     = idx;
  assign upd_pidx = upd_idx;
`endif

  // Combinational lookup; reads see the pre-update arrays (no bypass).
  always_comb begin
    lk_entry      = btb_q[idx];
    lk_ctr        = pht_q[pidx];
    hit           = lk_entry.valid && (lk_entry.tag == tag);
    predict_taken = hit && (lk_entry.uncond || (lk_ctr inside {WEAK_T, STRONG_T}));
    predicted_pc  = predict_taken ? lk_entry.target : fetch_pc + 32'd4;
  end

  bp_sat_ctr2 u_sat_ctr (
    .ctr      (pht_q[upd_pidx]),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );

  // Learn from resolved control flow and keep saturating statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Entries); i++) begin
        btb_q[i] <= '0;
        pht_q[i] <= PHT_RESET;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        btb_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target,
                            uncond: !upd_is_cond};
      end
      if (upd_is_cond) begin
        pht_q[upd_pidx] <= ctr_next;
      end
      if (branch_count_q != '1) begin
        branch_count_q <= branch_count_q + 32'd1;
      end
      if (upd_mispredict && (mispredict_count_q != '1)) begin
        mispredict_count_q <= mispredict_count_q + 32'd1;
      end
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage next-PC predictor for the 5-stage RV32I pipeline. Each cycle it looks up the current fetch PC in a direct-mapped branch target buffer (BTB) and a 2-bit-counter pattern history table (PHT), and drives `predicted_pc` combinationally to the datapath PC mux (`pcmux::pc_predict`). It learns from resolved control-flow instructions reported by the EX stage and keeps misprediction statistics.

## Interface
- `IDX_BITS`, default 5: log2 of BTB/PHT entries (32).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fetch_pc` in 32: PC currently presented to imem (the PC register output).
- `upd_valid` in 1: an EX-stage control-flow instruction commits to EX/MEM this cycle.
- `upd_pc` in 32: PC of the resolving instruction.
- `upd_is_cond` in 1: conditional branch (1) or jal/jalr (0).
- `upd_taken` in 1: actual direction (always 1 for jal/jalr).
- `upd_target` in 32: actual target, already masked for jalr.
- `upd_mispredict` in 1: datapath flagged a mispredict for this instruction.
- `predicted_pc` out 32: next fetch PC.
- `predict_taken` out 1: prediction is a redirect.
- `branch_count` out 32: resolved control-flow instructions.
- `mispredict_count` out 32: resolved mispredicts.

## Operation
- Index `idx = fetch_pc[IDX_BITS+1:2]`; tag `fetch_pc[31:IDX_BITS+2]`.
- BTB entry: `valid`, `tag`, `target[31:0]`, `uncond`. Hit = `valid && tag match`.
- `predict_taken = hit && (uncond || pht[pidx][1])`; `predicted_pc = predict_taken ? target : fetch_pc + 4`. No registers on the lookup path.
- PHT counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Counters saturate at 00 and 11.
- Update on rising edge when `upd_valid` (update index and tag are derived from `upd_pc`):
  - If `upd_taken`: write the BTB entry with `valid=1`, the new tag, `upd_target`, and `uncond=!upd_is_cond`. This replaces any previous occupant.
  - If `!upd_taken`: leave the BTB untouched.
  - If `upd_is_cond`: increment the PHT counter when taken, otherwise decrement.
  - Increment `branch_count`; increment `mispredict_count` if `upd_mispredict`. Both counters saturate at 32'hFFFF_FFFF.
- Reset clears all valid bits, sets all PHT counters to 01, and zeroes the counters and GHR. During reset the outputs are `predicted_pc = fetch_pc+4`, `predict_taken=0`, and both counts are 0.

## Timing
- Lookup latency is 0 cycles (combinational from `fetch_pc`). Update latency is 1 cycle: the new state is visible to a lookup on the cycle after `upd_valid`.
- Same-index read and update in the same cycle: the lookup returns the pre-update entry. There is no bypass.
- The upstream caller holds `upd_*` for a single cycle per instruction. Stalled EX cycles must not assert `upd_valid`, so there is no double counting.
- If `rst` is asserted during an update cycle, reset wins. The array and counters clear immediately, without waiting for a clock edge.

## Configuration
- `BP_GSHARE_EN` defined:
  - Add an `IDX_BITS`-wide global history register.
  - PHT index `pidx = idx ^ ghr` for lookup, and `upd_idx ^ ghr` for update.
  - On each `upd_valid && upd_is_cond`, shift `upd_taken` into the GHR LSB after the PHT write. The PHT write uses the pre-shift GHR.
  - The GHR resets to 0.
- `BP_GSHARE_EN` undefined: there is no GHR and `pidx = idx` (bimodal). The BTB indexing is identical in both builds.

## Structure
- Shared package `bp_pkg`:
  - `btb_entry_t` struct (`valid`, `tag`, `target`, `uncond`).
  - `pht_ctr_t` 2-bit enum (`STRONG_NT`, `WEAK_NT`, `WEAK_T`, `STRONG_T`).
  - Constant `PHT_RESET = WEAK_NT`.
- One sub-module, `bp_sat_ctr2`: pure next-state function for the 2-bit counter (`ctr`, `taken` → `ctr_next`). It is instantiated on the update path.

## Test plan
- After reset with `fetch_pc=0x4000_0000`: expect `predicted_pc=0x4000_0004`, `predict_taken=0`, and both counts 0.
- Update `pc=0x4000_0010`, cond, taken, target `0x4000_0100`. Next cycle, with `fetch_pc=0x4000_0010`, expect `predicted_pc=0x4000_0100` (counter 01→10).
- Resolve the same branch not-taken twice: the counter goes 10→01→00 and the prediction returns to `0x4000_0014`. A subsequent taken update gives 01, which still predicts `0x4000_0014`.
- jal at `0x4000_0020` to `0x4000_0400`: the entry is `uncond`, so it is predicted taken regardless of the PHT. Then `pc=0x4000_00A0` (same idx, different tag) taken to `0x4000_0800`: fetch of `0x4000_0020` now misses and returns `0x4000_0024`.
- Five updates, two with `upd_mispredict`: `branch_count=5`, `mispredict_count=2`. Assert `rst` asynchronously mid-cycle: both counts are 0 before the next edge.
- With `BP_GSHARE_EN`: update `pc=0x4000_0010` taken twice (first with GHR=0, then GHR=1). Check that the lookup of `0x4000_0010` uses `pidx=4^3=7` once GHR=3.
